huffman_packer: RTL
===================

# huffman_packer

Downstream stage of the Huffman encoder. Latches the six code/mask pairs the encoder publishes on `code_valid`, then turns a stream of gray symbols 1..6 into a packed, MSB-first byte stream with valid/ready handshakes. A flush pads the final partial byte with zeros.

## Interface
Parameters
- `ACC_W`, default 16: accumulator width in bits; fixed at 16.
- `SYM_W`, default 8: symbol and code/mask width.

Ports
- `clk`, in, 1: clock.
- `reset`, in, 1: asynchronous, active-high.
- `code_valid`, in, 1: one-cycle pulse; HC1..HC6 and M1..M6 are valid.
- `HC1`..`HC6`, in, 8 each: code values, LSB-aligned.
- `M1`..`M6`, in, 8 each: masks with contiguous ones from the LSB; code length = popcount, range 1..8.
- `sym_valid`, in, 1: symbol offered.
- `sym_ready`, out, 1: symbol accepted when high together with `sym_valid`.
- `sym_data`, in, 8: symbol; legal values 1..6.
- `flush`, in, 1: end-of-stream pulse.
- `byte_valid`, out, 1: output byte present.
- `byte_ready`, in, 1: downstream accepts the byte.
- `byte_data`, out, 8: packed byte; first code bit is in bit 7.
- `bit_total`, out, 16: code bits appended since the last table load; saturates at 0xFFFF; excludes padding.
- `done`, out, 1: level; stream fully emitted.
- `err`, out, 1: sticky illegal-symbol flag.

## Operation
- FSM states: IDLE, RUN, FLUSH, DONE. Reset state is IDLE.
  - IDLE→RUN on `code_valid`.
  - RUN→FLUSH on `flush`.
  - FLUSH→DONE when `bit_cnt==0` and `!byte_valid`.
  - DONE→RUN on `code_valid`.
  - `code_valid` in RUN or FLUSH is ignored.
- Table load, on `code_valid` in IDLE or DONE:
  - Latch all 12 inputs.
  - Compute the 4-bit lengths.
  - Clear `bit_total`, the accumulator, `bit_cnt` and `err`.
- `sym_ready` = (state==RUN) && (`bit_cnt` <= 8). It depends on registers only.
- Accumulator is 16 bits, MSB-aligned; `bit_cnt` is 0..16.
  - An accepted legal symbol k appends HCk[len-1:0], MSB first, directly after the existing bits.
- Drain: when `bit_cnt` >= 8 and (`!byte_valid` || `byte_ready`):
  - Load the top 8 accumulator bits into `byte_data`.
  - Shift the accumulator left by 8.
- Drain and append in the same cycle: new `bit_cnt` = `bit_cnt` − 8·drain + len·accept. The append position uses the post-drain count.
- `byte_valid` clears on `byte_ready` unless a new byte is loaded in that cycle.
- FLUSH: when 0 < `bit_cnt` < 8, set `bit_cnt` to 8 with zero padding; the normal drain then emits the byte. Flushing with `bit_cnt==0` emits no byte.
- `flush` in IDLE or DONE is ignored. `flush` coinciding with an accepted symbol: the symbol is appended first.

## Timing
- Accepting edge: accumulator updated.
- Earliest `byte_valid`: the following edge, i.e. one cycle after `bit_cnt` reaches >= 8.
- Full throughput: one symbol per cycle, provided `byte_ready` is held high.
- Reset values: `sym_ready`=0, `byte_valid`=0, `byte_data`=0, `bit_total`=0, `done`=0, `err`=0.
- Table registers reset to 0. Reset mid-stream discards all buffered bits.

## Configuration
- `HUFFMAN_PACKER_ERR_EN` defined:
  - A symbol of 0 or 7..255 is consumed and appends no bits.
  - `err` sets the next edge and stays high until reset or table load.
- Undefined:
  - Illegal symbols are consumed silently.
  - `err` is tied to 0.

## Structure
- Shared package `huffman_pkg`:
  - State enum.
  - `SYM_NUM=6`.
  - Code and mask width constants.
  - Length function: 8-bit mask → 4-bit popcount.
- One sub-module, `huffman_bit_acc`: holds the accumulator, `bit_cnt`, and the append/drain/pad logic. The FSM, table, and handshakes stay in the top.

## Test plan
Table used throughout:

- 1="1" (HC 01, M 01)
- 2="00" (00/03)
- 3="011" (03/07)
- 4="0100" (04/0F)
- 5="01011" (0B/1F)
- 6="01010" (0A/1F)

Scenarios:

- Eight symbol 1s, `byte_ready`=1, then `flush` → one byte 0xFF, no pad byte, `done`=1, `bit_total`=8.
- Symbols 3,3,2 then `flush` → byte 0x6C, `bit_total`=8.
- Symbol 5 then `flush` → byte 0x58; `bit_total`=5.
- Symbol 1s continuously with `byte_ready`=0 → exactly 17 accepted, then `sym_ready`=0 with `bit_cnt`=9 and `byte_data`=0xFF held. Release `byte_ready` → stream resumes with no bit lost.
- With `HUFFMAN_PACKER_ERR_EN`: symbols 0,4,4 then `flush` → `err`=1, byte 0x44, `bit_total`=8.
- `reset` asserted after 3 symbols → all outputs 0, IDLE. A new `code_valid` is required before `sym_ready` rises.

Source files
------------

// File: rtl/huffman_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : huffman_pkg
//  Brief    : Shared types, constants and the mask-length helper for the
//             Huffman packer slice.
//  Revision : 1.0 - initial release
// ============================================================================
package huffman_pkg;

    localparam int SYM_NUM = 6;     // gray symbols 1..6
    localparam int CODE_W  = 8;     // code and mask width
    localparam int LEN_W   = 4;     // code length 1..8
    localparam int CNT_W   = 5;     // accumulator fill level 0..16

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Code length is the popcount of the LSB-contiguous mask.
    function automatic logic [LEN_W-1:0] mask_len(input logic [CODE_W-1:0] mask);
        logic [LEN_W-1:0] n;
        n = '0;
        for (int i = 0; i < CODE_W; i++) begin
            n = n + {{(LEN_W-1){1'b0}}, mask[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/huffman_bit_acc.sv
`default_nettype none
// ============================================================================
//  Module   : huffman_bit_acc
//  Brief    : MSB-aligned bit accumulator. Appends variable-length codes,
//             drains whole bytes from the top and zero-pads a partial byte
//             on request.
//  Revision : 1.0 - initial release
// ============================================================================
module huffman_bit_acc
    import huffman_pkg::*;
#(
    parameter int ACC_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              append_i,
    input  logic [CODE_W-1:0] code_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              pad_i,
    input  logic              drain_ok_i,
    output logic              drain_o,
    output logic [CODE_W-1:0] drain_byte_o,
    output logic [CNT_W-1:0]  bit_cnt_o
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [ACC_W-1:0] w_acc_shift;
    logic [ACC_W-1:0] w_code_ext;
    logic [CNT_W-1:0] w_cnt_post;
    logic [CNT_W-1:0] w_sh;

    assign w_code_ext = {{(ACC_W-CODE_W){1'b0}}, code_i};

    // A byte leaves whenever one is complete and the output register is free.
    assign drain_o      = (cnt_q >= CNT_W'(CODE_W)) && drain_ok_i;
    assign drain_byte_o = acc_q[ACC_W-1 -: CODE_W];
    assign bit_cnt_o    = cnt_q;

    // The append position is computed against the post-drain fill level so
    // that a drain and an append can share one cycle.
    assign w_acc_shift = drain_o ? (acc_q << CODE_W) : acc_q;
    assign w_cnt_post  = drain_o ? (cnt_q - CNT_W'(CODE_W)) : cnt_q;
    assign w_sh        = CNT_W'(ACC_W) - w_cnt_post - {1'b0, len_i};

    // Next-state for accumulator contents and fill level.
    always_comb begin
        acc_d = w_acc_shift;
        cnt_d = w_cnt_post;
        if (clear_i) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (append_i) begin
            acc_d = w_acc_shift | (w_code_ext << w_sh);
            cnt_d = w_cnt_post + {1'b0, len_i};
        end else if (pad_i && (cnt_q != '0) && (cnt_q < CNT_W'(CODE_W))) begin
            // Bits below the fill level are always zero, so raising the
            // count is enough to pad the partial byte.
            cnt_d = CNT_W'(CODE_W);
        end
    end

    // Accumulator state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/huffman_packer.sv
`default_nettype none
// ============================================================================
//  Module   : huffman_packer
//  Brief    : Latches a six-entry Huffman code table and packs a stream of
//             gray symbols 1..6 into MSB-first bytes with valid/ready
//             handshakes; flush pads the last partial byte with zeros.
//             Optional feature macro: HUFFMAN_PACKER_ERR_EN (sticky err on
//             illegal symbols; err tied low when undefined).
//  Revision : 1.0 - initial release
// ============================================================================
module huffman_packer
    import huffman_pkg::*;
#(
    parameter int ACC_W = 16,
    parameter int SYM_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             code_valid,
    input  logic [SYM_W-1:0] HC1,
    input  logic [SYM_W-1:0] HC2,
    input  logic [SYM_W-1:0] HC3,
    input  logic [SYM_W-1:0] HC4,
    input  logic [SYM_W-1:0] HC5,
    input  logic [SYM_W-1:0] HC6,
    input  logic [SYM_W-1:0] M1,
    input  logic [SYM_W-1:0] M2,
    input  logic [SYM_W-1:0] M3,
    input  logic [SYM_W-1:0] M4,
    input  logic [SYM_W-1:0] M5,
    input  logic [SYM_W-1:0] M6,
    input  logic             sym_valid,
    output logic             sym_ready,
    input  logic [SYM_W-1:0] sym_data,
    input  logic             flush,
    output logic             byte_valid,
    input  logic             byte_ready,
    output logic [7:0]       byte_data,
    output logic [15:0]      bit_total,
    output logic             done,
    output logic             err
);

    state_e state_q, state_d;

    logic [SYM_W-1:0] hc_q   [SYM_NUM];
    logic [SYM_W-1:0] mask_q [SYM_NUM];
    logic [LEN_W-1:0] len_q  [SYM_NUM];
    logic [SYM_W-1:0] w_hc_in   [SYM_NUM];
    logic [SYM_W-1:0] w_mask_in [SYM_NUM];

    logic             byte_valid_q;
    logic [7:0]       byte_data_q;
    logic [15:0]      bit_total_q;

    logic             w_load;
    logic             w_accept;
    logic             w_legal;
    logic [SYM_W-1:0] w_code;
    logic [LEN_W-1:0] w_len;
    logic             w_drain;
    logic [7:0]       w_drain_byte;
    logic [CNT_W-1:0] w_bit_cnt;
    logic [16:0]      w_total_sum;

    assign w_hc_in[0] = HC1;  assign w_mask_in[0] = M1;
    assign w_hc_in[1] = HC2;  assign w_mask_in[1] = M2;
    assign w_hc_in[2] = HC3;  assign w_mask_in[2] = M3;
    assign w_hc_in[3] = HC4;  assign w_mask_in[3] = M4;
    assign w_hc_in[4] = HC5;  assign w_mask_in[4] = M5;
    assign w_hc_in[5] = HC6;  assign w_mask_in[5] = M6;

    // A table only loads between streams; code_valid mid-stream is ignored.
    assign w_load   = code_valid && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign w_accept = sym_valid && sym_ready;

    assign sym_ready  = (state_q == ST_RUN) && (w_bit_cnt <= CNT_W'(8));
    assign byte_valid = byte_valid_q;
    assign byte_data  = byte_data_q;
    assign bit_total  = bit_total_q;
    assign done       = (state_q == ST_DONE);

    // Table lookup for the offered symbol; anything outside 1..6 is illegal.
    always_comb begin
        w_code  = '0;
        w_len   = '0;
        w_legal = 1'b0;
        for (int i = 0; i < SYM_NUM; i++) begin
            if (sym_data == SYM_W'(i + 1)) begin
                w_code  = hc_q[i] & mask_q[i];
                w_len   = len_q[i];
                w_legal = 1'b1;
            end
        end
    end

    // Stream FSM next-state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE,
            ST_DONE:  if (code_valid) state_d = ST_RUN;
            ST_RUN:   if (flush) state_d = ST_FLUSH;
            ST_FLUSH: if ((w_bit_cnt == '0) && !byte_valid_q) state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Code table latch with lengths precomputed at load time.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYM_NUM; i++) begin
                hc_q[i]   <= '0;
                mask_q[i] <= '0;
                len_q[i]  <= '0;
            end
        end else if (w_load) begin
            for (int i = 0; i < SYM_NUM; i++) begin
                hc_q[i]   <= w_hc_in[i];
                mask_q[i] <= w_mask_in[i];
                len_q[i]  <= mask_len(w_mask_in[i]);
            end
        end
    end

    huffman_bit_acc #(
        .ACC_W (ACC_W)
    ) u_bit_acc (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (w_load),
        .append_i     (w_accept && w_legal),
        .code_i       (w_code),
        .len_i        (w_len),
        .pad_i        (state_q == ST_FLUSH),
        .drain_ok_i   (!byte_valid_q || byte_ready),
        .drain_o      (w_drain),
        .drain_byte_o (w_drain_byte),
        .bit_cnt_o    (w_bit_cnt)
    );

    // Output byte register: a fresh byte wins over a handshake clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_valid_q <= 1'b0;
            byte_data_q  <= '0;
        end else if (w_drain) begin
            byte_valid_q <= 1'b1;
            byte_data_q  <= w_drain_byte;
        end else if (byte_ready) begin
            byte_valid_q <= 1'b0;
        end
    end

    assign w_total_sum = {1'b0, bit_total_q} + {13'd0, w_len};

    // Saturating count of code bits appended since the last table load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_total_q <= '0;
        end else if (w_load) begin
            bit_total_q <= '0;
        end else if (w_accept && w_legal) begin
            bit_total_q <= w_total_sum[16] ? 16'hFFFF : w_total_sum[15:0];
        end
    end

`ifdef HUFFMAN_PACKER_ERR_EN
    logic err_q;

    // Sticky illegal-symbol flag, cleared only by reset or a table load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (w_load) begin
            err_q <= 1'b0;
        end else if (w_accept && !w_legal) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
`default_nettype wire
